// File: rtl/ahb_sram_backend_pkg.sv
// Shared HSIZE encodings and byte-lane helpers for the AHB SRAM back end.
package ahb_sram_backend_pkg;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam int unsigned LANES      = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;

    // Decoded byte-lane view of one address phase.
    typedef struct packed {
        logic [LANES-1:0] mask;
        logic             misalign;
    } lane_info_t;

    // Little-endian byte-lane enable for an access of the given HSIZE.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] addr_lo,
                                                   input logic [2:0] hsize);
        logic [LANES-1:0] m;
        m = 4'b0000;
        case (hsize)
            SIZE_BYTE: m = 4'b0001 << addr_lo;
            SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Natural-alignment check; anything wider than a word is unsupported.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [2:0] hsize);
        logic mis;
        mis = 1'b0;
        case (hsize)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = (addr_lo != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Combined lane decode used at address-phase capture.
    function automatic lane_info_t decode_lanes(input logic [1:0] addr_lo,
                                                input logic [2:0] hsize);
        lane_info_t li;
        li.mask     = lane_mask(addr_lo, hsize);
        li.misalign = is_misaligned(addr_lo, hsize);
        return li;
    endfunction

    // Overlay the enabled lanes of new_word onto old_word.
    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [LANES-1:0]  mask);
        logic [DATA_W-1:0] w;
        w = old_word;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (mask[k]) begin
                w[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ahb_sram_backend_sram_byte_array.sv
// DEPTH x 32 storage with per-byte write enables and an asynchronous read port.
module sram_byte_array
    import ahb_sram_backend_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic              i_clk,
    input  logic [LANES-1:0]  i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Byte-lane write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (i_we[k]) begin
                r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_sram_backend.sv
// AHB slave data-side back end: captures the address phase, inserts wait
// states, commits lane-masked writes and returns registered read data.
module ahb_sram_backend
    import ahb_sram_backend_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS     = 32'h0000_0000,
    parameter int unsigned NUMBER_ADDRESSES = 1024,
    parameter int unsigned WAIT_CYCLES      = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    input  logic        r_prep,
    input  logic        w_prep,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        slave_wait,
    output logic        burst_cancel
);

    localparam int unsigned DEPTH     = NUMBER_ADDRESSES / 4;
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    // With no wait states the read must be fetched on the capture edge itself.
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    // Captured transfer state
    logic [AW-1:0]       r_idx;
    logic [LANES-1:0]    r_mask;
    logic                r_misalign;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata;

    // Combinational control
    lane_info_t          w_lane;
    logic [AW-1:0]       w_cap_idx;
    logic [AW-1:0]       w_rd_idx;
    logic                w_data_phase;
    logic                w_wait;
    logic                w_cap;
    logic                w_complete;
    logic                w_commit;
    logic                w_load;
    logic                w_fwd;
    logic [LANES-1:0]    w_we;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_data_phase = ren | wen;
    // Misaligned transfers never stall; they are cancelled instead.
    assign w_wait       = w_data_phase && (r_cnt != '0) && !r_misalign;
    // The front end holds the address phase while we stall, so ignore it then.
    assign w_cap        = (r_prep | w_prep) && !w_wait;
    assign w_lane       = decode_lanes(addr[1:0], size);
    assign w_cap_idx    = AW'((addr - BASE_ADDRESS) >> 2);

    assign w_complete   = w_data_phase && !w_wait;
    assign w_commit     = wen && w_complete && !r_misalign;
    assign w_we         = w_commit ? r_mask : '0;

    // Read fetch edge: capture edge for zero-wait, else the edge ending the last wait.
    assign w_load       = ZERO_WAIT ? (w_cap && r_prep && !w_lane.misalign)
                                    : (ren && (r_cnt == CNT_W'(1)) && !r_misalign);
    assign w_rd_idx     = (ZERO_WAIT && w_cap) ? w_cap_idx : r_idx;

    // A write landing on the same edge as a read fetch of that word is forwarded.
    assign w_fwd        = w_commit && (r_idx == w_rd_idx);
    assign w_rd_word    = w_fwd ? merge_lanes(w_mem_rdata, wdata, r_mask) : w_mem_rdata;

    assign rdata        = r_rdata;
    assign slave_wait   = w_wait;
    assign burst_cancel = w_data_phase && r_misalign;

    // Storage array
    sram_byte_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_mem_rdata)
    );

    // Address-phase capture, wait countdown and one-shot misalign clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_idx      <= '0;
            r_mask     <= '0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else if (w_cap) begin
            r_idx      <= w_cap_idx;
            r_mask     <= w_lane.mask;
            r_misalign <= w_lane.misalign;
            r_cnt      <= WAIT_INIT;
        end else if (w_data_phase) begin
            if (r_misalign) begin
                r_misalign <= 1'b0;
                r_cnt      <= '0;
            end else if (r_cnt != '0) begin
                r_cnt      <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Registered read data, updated only on a read fetch edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rdata <= '0;
        end else if (w_load) begin
            r_rdata <= w_rd_word;
        end
    end

endmodule

// File: tb/tb_ahb_sram_backend.sv
// Directed bench: zero-wait instance (base 0) and 3-wait instance (base 0x1000).
module tb_ahb_sram_backend;
    import ahb_sram_backend_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;

    logic [31:0] addr0, wdata0, rdata0;
    logic [2:0]  size0;
    logic        rp0, wp0, ren0, wen0, wait0, bc0;

    logic [31:0] addr3, wdata3, rdata3;
    logic [2:0]  size3;
    logic        rp3, wp3, ren3, wen3, wait3, bc3;

    int n_tests = 0;
    int n_fail  = 0;
    bit saw_wait0 = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_sram_backend #(
        .BASE_ADDRESS     (32'h0000_0000),
        .NUMBER_ADDRESSES (1024),
        .WAIT_CYCLES      (0)
    ) dut0 (
        .HCLK (HCLK), .HRESETn (HRESETn),
        .addr (addr0), .wdata (wdata0), .size (size0),
        .r_prep (rp0), .w_prep (wp0), .ren (ren0), .wen (wen0),
        .rdata (rdata0), .slave_wait (wait0), .burst_cancel (bc0)
    );

    ahb_sram_backend #(
        .BASE_ADDRESS     (32'h0000_1000),
        .NUMBER_ADDRESSES (1024),
        .WAIT_CYCLES      (3)
    ) dut3 (
        .HCLK (HCLK), .HRESETn (HRESETn),
        .addr (addr3), .wdata (wdata3), .size (size3),
        .r_prep (rp3), .w_prep (wp3), .ren (ren3), .wen (wen3),
        .rdata (rdata3), .slave_wait (wait3), .burst_cancel (bc3)
    );

    // The zero-wait instance must never stall.
    always @(negedge HCLK) if (wait0 === 1'b1) saw_wait0 = 1'b1;

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic write0(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        wp0 = 1'b1; addr0 = a; size0 = s;
        tick;
        wp0 = 1'b0; wen0 = 1'b1; wdata0 = d;
        tick;
        wen0 = 1'b0;
    endtask

    task automatic read0(input logic [31:0] a, input logic [2:0] s, output logic [31:0] d);
        rp0 = 1'b1; addr0 = a; size0 = s;
        tick;
        rp0 = 1'b0; ren0 = 1'b1;
        @(negedge HCLK);
        d = rdata0;
        tick;
        ren0 = 1'b0;
    endtask

    // Write data phase overlapped with the address phase of a read.
    task automatic wr_then_rd0(input logic [31:0] wa, input logic [2:0] ws, input logic [31:0] wd,
                               input logic [31:0] ra, output logic [31:0] d);
        wp0 = 1'b1; addr0 = wa; size0 = ws;
        tick;
        wp0 = 1'b0; wen0 = 1'b1; wdata0 = wd;
        rp0 = 1'b1; addr0 = ra; size0 = SIZE_WORD;
        tick;
        wen0 = 1'b0; rp0 = 1'b0; ren0 = 1'b1;
        @(negedge HCLK);
        d = rdata0;
        tick;
        ren0 = 1'b0;
    endtask

    task automatic write3(input logic [31:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        wp3 = 1'b1; addr3 = a; size3 = SIZE_WORD;
        tick;
        wp3 = 1'b0; wen3 = 1'b1; wdata3 = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge HCLK);
            if (wait3 === 1'b0) done = 1'b1;
            else tick;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL write3_timeout: slave_wait still %b after 20 cycles, required 0", wait3);
        end
        tick;
        wen3 = 1'b0;
    endtask

    task automatic read3(input logic [31:0] a, output logic [31:0] d, output int waits);
        bit done;
        done = 1'b0;
        waits = 0;
        d = '0;
        rp3 = 1'b1; addr3 = a; size3 = SIZE_WORD;
        tick;
        rp3 = 1'b0; ren3 = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge HCLK);
            if (wait3 === 1'b0) begin
                done = 1'b1;
                d = rdata3;
            end else begin
                waits++;
                tick;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL read3_timeout: slave_wait still %b after 20 cycles, required 0", wait3);
        end
        tick;
        ren3 = 1'b0;
    endtask

    task automatic test_reset;
        addr0 = '0; wdata0 = '0; size0 = '0; rp0 = 0; wp0 = 0; ren0 = 0; wen0 = 0;
        addr3 = '0; wdata3 = '0; size3 = '0; rp3 = 0; wp3 = 0; ren3 = 0; wen3 = 0;
        #1 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        n_tests++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 00000000", rdata0); end
        n_tests++; if (wait0 !== 1'b0) begin n_fail++; $display("FAIL reset_wait0: got %b expected 0", wait0); end
        n_tests++; if (bc0 !== 1'b0) begin n_fail++; $display("FAIL reset_cancel0: got %b expected 0", bc0); end
        n_tests++; if (rdata3 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3: got %h expected 00000000", rdata3); end
        n_tests++; if (wait3 !== 1'b0) begin n_fail++; $display("FAIL reset_wait3: got %b expected 0", wait3); end
        n_tests++; if (bc3 !== 1'b0) begin n_fail++; $display("FAIL reset_cancel3: got %b expected 0", bc3); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick;
    endtask

    task automatic test_word_rw;
        logic [31:0] d;
        write0(32'h10, SIZE_WORD, 32'hDEAD_BEEF);
        write0(32'h14, SIZE_WORD, 32'h1357_9BDF);
        read0(32'h10, SIZE_WORD, d);
        n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_rd_10: got %h expected deadbeef", d); end
        read0(32'h14, SIZE_WORD, d);
        n_tests++; if (d !== 32'h1357_9BDF) begin n_fail++; $display("FAIL word_rd_14: got %h expected 13579bdf", d); end
        n_tests++; if (saw_wait0 !== 1'b0) begin n_fail++; $display("FAIL zero_wait_stall: slave_wait seen %b expected 0", saw_wait0); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        write0(32'h20, SIZE_WORD, 32'hAABB_CCDD);
        write0(32'h21, SIZE_BYTE, 32'hFFFF_11FF);
        read0(32'h20, SIZE_WORD, d);
        n_tests++; if (d !== 32'hAABB_11DD) begin n_fail++; $display("FAIL byte_lane1: got %h expected aabb11dd", d); end
        write0(32'h20, SIZE_WORD, 32'hAABB_CCDD);
        write0(32'h22, SIZE_HALF, 32'h5566_EEEE);
        read0(32'h20, SIZE_WORD, d);
        n_tests++; if (d !== 32'h5566_CCDD) begin n_fail++; $display("FAIL half_upper: got %h expected 5566ccdd", d); end
        write0(32'h23, SIZE_BYTE, 32'h7700_0000);
        read0(32'h20, SIZE_WORD, d);
        n_tests++; if (d !== 32'h7766_CCDD) begin n_fail++; $display("FAIL byte_lane3: got %h expected 7766ccdd", d); end
        write0(32'h20, SIZE_HALF, 32'h1234_9999);
        read0(32'h20, SIZE_WORD, d);
        n_tests++; if (d !== 32'h7766_9999) begin n_fail++; $display("FAIL half_lower: got %h expected 77669999", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        write0(32'h30, SIZE_WORD, 32'hCAFE_F00D);
        wr_then_rd0(32'h30, SIZE_WORD, 32'h1234_5678, 32'h30, d);
        n_tests++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_word: got %h expected 12345678", d); end
        wr_then_rd0(32'h31, SIZE_BYTE, 32'h0000_AB00, 32'h30, d);
        n_tests++; if (d !== 32'h1234_AB78) begin n_fail++; $display("FAIL b2b_byte_merge: got %h expected 1234ab78", d); end
        wr_then_rd0(32'h34, SIZE_WORD, 32'hFFFF_FFFF, 32'h30, d);
        n_tests++; if (d !== 32'h1234_AB78) begin n_fail++; $display("FAIL b2b_other_addr: got %h expected 1234ab78", d); end
        read0(32'h34, SIZE_WORD, d);
        n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_second_word: got %h expected ffffffff", d); end
    endtask

    task automatic test_misaligned;
        logic [31:0] d;
        write0(32'h40, SIZE_WORD, 32'h0102_0304);
        read0(32'h40, SIZE_WORD, d);
        n_tests++; if (d !== 32'h0102_0304) begin n_fail++; $display("FAIL mis_setup: got %h expected 01020304", d); end
        // Halfword write at odd address
        wp0 = 1'b1; addr0 = 32'h41; size0 = SIZE_HALF;
        tick;
        wp0 = 1'b0; wen0 = 1'b1; wdata0 = 32'hFFFF_FFFF;
        @(negedge HCLK);
        n_tests++; if (bc0 !== 1'b1) begin n_fail++; $display("FAIL mis_half_cancel: got %b expected 1", bc0); end
        n_tests++; if (wait0 !== 1'b0) begin n_fail++; $display("FAIL mis_half_wait: got %b expected 0", wait0); end
        tick;
        wen0 = 1'b0;
        @(negedge HCLK);
        n_tests++; if (bc0 !== 1'b0) begin n_fail++; $display("FAIL mis_half_pulse: got %b expected 0", bc0); end
        tick;
        // Word read at 0x42
        rp0 = 1'b1; addr0 = 32'h42; size0 = SIZE_WORD;
        tick;
        rp0 = 1'b0; ren0 = 1'b1;
        @(negedge HCLK);
        n_tests++; if (bc0 !== 1'b1) begin n_fail++; $display("FAIL mis_word_cancel: got %b expected 1", bc0); end
        n_tests++; if (rdata0 !== 32'h0102_0304) begin n_fail++; $display("FAIL mis_word_rdata: got %h expected 01020304", rdata0); end
        tick;
        ren0 = 1'b0;
        @(negedge HCLK);
        n_tests++; if (bc0 !== 1'b0) begin n_fail++; $display("FAIL mis_word_pulse: got %b expected 0", bc0); end
        tick;
        // Word write at 0x42 must not touch memory
        write0(32'h42, SIZE_WORD, 32'hEEEE_EEEE);
        read0(32'h42, SIZE_HALF, d);
        n_tests++; if (d !== 32'h0102_0304) begin n_fail++; $display("FAIL mis_mem_intact: got %h expected 01020304", d); end
    endtask

    task automatic test_wait_states;
        logic [31:0] exp_d;
        write3(32'h1010, 32'hA5A5_0001);
        write3(32'h1014, 32'h5A5A_0002);
        rp3 = 1'b1; addr3 = 32'h1010; size3 = SIZE_WORD;
        tick;
        // Next address phase held by the front end throughout the stall.
        addr3 = 32'h1014; ren3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            n_tests++; if (wait3 !== (c < 3)) begin n_fail++; $display("FAIL ws1_wait_c%0d: got %b expected %b", c, wait3, (c < 3)); end
            exp_d = (c < 3) ? 32'h0 : 32'hA5A5_0001;
            n_tests++; if (rdata3 !== exp_d) begin n_fail++; $display("FAIL ws1_rdata_c%0d: got %h expected %h", c, rdata3, exp_d); end
            tick;
        end
        rp3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            n_tests++; if (wait3 !== (c < 3)) begin n_fail++; $display("FAIL ws2_wait_c%0d: got %b expected %b", c, wait3, (c < 3)); end
            exp_d = (c < 3) ? 32'hA5A5_0001 : 32'h5A5A_0002;
            n_tests++; if (rdata3 !== exp_d) begin n_fail++; $display("FAIL ws2_rdata_c%0d: got %h expected %h", c, rdata3, exp_d); end
            tick;
        end
        ren3 = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] d;
        int          waits;
        write3(32'h1020, 32'h0BAD_F00D);
        wp3 = 1'b1; addr3 = 32'h1020; size3 = SIZE_WORD;
        tick;
        wp3 = 1'b0; wen3 = 1'b1; wdata3 = 32'hFFFF_FFFF;
        @(negedge HCLK);
        n_tests++; if (wait3 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wait: got %b expected 1", wait3); end
        #2 HRESETn = 1'b0;
        #1;
        n_tests++; if (rdata3 !== 32'h0) begin n_fail++; $display("FAIL rst_async_rdata3: got %h expected 00000000", rdata3); end
        n_tests++; if (wait3 !== 1'b0) begin n_fail++; $display("FAIL rst_async_wait3: got %b expected 0", wait3); end
        n_tests++; if (bc3 !== 1'b0) begin n_fail++; $display("FAIL rst_async_cancel3: got %b expected 0", bc3); end
        n_tests++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL rst_async_rdata0: got %h expected 00000000", rdata0); end
        wen3 = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick;
        read3(32'h1020, d, waits);
        n_tests++; if (d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_mem_intact: got %h expected 0badf00d", d); end
        n_tests++; if (waits !== 3) begin n_fail++; $display("FAIL rst_read_waits: got %0d expected 3", waits); end
        read0(32'h10, SIZE_WORD, d);
        n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_mem0_intact: got %h expected deadbeef", d); end
    endtask

    initial begin
        test_reset;
        test_word_rw;
        test_byte_lanes;
        test_back_to_back;
        test_misaligned;
        test_wait_states;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
